// File: rtl/matrix_scan.sv
// matrix_scan: time-multiplexed 8x8 LED driver for a Game of Life board.
// New boards are staged in a pending register. They are copied into the
// displayed frame only between frames, so a frame never tears mid-scan.
// Each row is preceded by BLANK_CYC all-off cycles to suppress ghosting.
//
// Handshake: board_valid is a single-cycle strobe with no ready. Every strobe
// overwrites the pending board (the last strobe wins). A strobe in the LOAD
// cycle keeps pending_valid set, so that board is shown in the next frame.
module matrix_scan #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] board_in,
  input  logic        board_valid,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_out,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    DRIVE = 2'd3
  } state_t;

  // One counter serves both BLANK and DRIVE, so it is sized for the longer phase.
  localparam int MAX_CYC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
  // The drive cycle before the last one. frame_done is registered at this
  // edge so that it is high during the final drive cycle of row 7.
  localparam logic [CW-1:0] DRIVE_PRE  = CW'((CLK_DIV >= 2) ? (CLK_DIV - 2) : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic          ONE_CYCLE_DRIVE = (CLK_DIV == 1);

  state_t        state;
  logic [63:0]   pending;
  logic          pending_valid;
  logic [63:0]   frame;
  logic          loaded;
  logic [2:0]    row;
  logic [CW-1:0] cnt;

  assign dbg_state = state;

  // Scan FSM. It owns the staging registers, the frame and the registered row/column drives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pending       <= '0;
      pending_valid <= 1'b0;
      frame         <= '0;
      loaded        <= 1'b0;
      row           <= '0;
      cnt           <= '0;
      row_sel       <= '0;
      col_out       <= '0;
      frame_done    <= 1'b0;
    end else begin
      if (board_valid) pending <= board_in;

      if (!enable) begin
        // Stop scanning but keep frame and pending. Re-entry restarts at row 0.
        state      <= IDLE;
        row        <= '0;
        cnt        <= '0;
        row_sel    <= '0;
        col_out    <= '0;
        frame_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pending_valid) begin
              state <= LOAD;
            end else if (loaded) begin
              state <= BLANK;
              row   <= '0;
              cnt   <= '0;
            end
          end

          LOAD: begin
            frame         <= pending;
            loaded        <= 1'b1;
            pending_valid <= 1'b0;
            row           <= '0;
            cnt           <= '0;
            state         <= BLANK;
          end

          BLANK: begin
            if (cnt == BLANK_LAST) begin
              cnt        <= '0;
              state      <= DRIVE;
              row_sel    <= 8'b1 << row;
              col_out    <= frame[{row, 3'b000} +: 8];
              frame_done <= (row == 3'd7) && ONE_CYCLE_DRIVE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          DRIVE: begin
            if (cnt == DRIVE_LAST) begin
              cnt        <= '0;
              row_sel    <= '0;
              col_out    <= '0;
              frame_done <= 1'b0;
              if (row != 3'd7) begin
                row   <= row + 3'd1;
                state <= BLANK;
              end else if (pending_valid) begin
                state <= LOAD;
              end else begin
                row   <= '0;
                state <= BLANK;
              end
            end else begin
              cnt        <= cnt + CNT_ONE;
              frame_done <= (row == 3'd7) && (cnt == DRIVE_PRE);
            end
          end

          default: state <= IDLE;
        endcase
      end

      // Written last, so a capture wins over the clear in LOAD.
      if (board_valid) pending_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: directed scenarios plus randomized traffic for matrix_scan.
// The reference model treats a running scan as a position within an
// 8*(BLANK+DRIVE)-cycle frame timeline. Expected outputs are computed
// arithmetically from that position.
module tb_matrix_scan;

  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 2;
  localparam int ROW_LEN   = BLANK_CYC + CLK_DIV;
  localparam int PERIOD    = 8 * ROW_LEN;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] board_in = '0;
  logic        board_valid = 1'b0;
  logic [7:0]  row_sel;
  logic [7:0]  col_out;
  logic        frame_done;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  matrix_scan #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .board_in    (board_in),
    .board_valid (board_valid),
    .row_sel     (row_sel),
    .col_out     (col_out),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_pend;
  logic        m_pend_v;
  logic [63:0] m_frame;
  logic        m_loaded;
  logic        m_active;   // currently inside a frame timeline
  logic        m_in_load;  // the single load cycle between frames
  int          m_pos;      // cycle position within the frame timeline

  task automatic model_reset();
    m_pend = '0; m_pend_v = 1'b0; m_frame = '0; m_loaded = 1'b0;
    m_active = 1'b0; m_in_load = 1'b0; m_pos = 0;
  endtask

  // Advance the model by one rising edge, using the inputs held before the edge.
  task automatic model_step();
    logic old_pv;
    if (!reset) begin
      model_reset();
      return;
    end
    old_pv = m_pend_v;
    if (!enable) begin
      m_active = 1'b0; m_in_load = 1'b0;
    end else if (m_in_load) begin
      m_frame = m_pend; m_loaded = 1'b1; m_pend_v = 1'b0;
      m_in_load = 1'b0; m_active = 1'b1; m_pos = 0;
    end else if (m_active) begin
      if (m_pos == PERIOD - 1) begin
        if (old_pv) begin m_active = 1'b0; m_in_load = 1'b1; end
        else m_pos = 0;
      end else begin
        m_pos++;
      end
    end else begin
      if (old_pv) m_in_load = 1'b1;
      else if (m_loaded) begin m_active = 1'b1; m_pos = 0; end
    end
    if (board_valid) begin m_pend = board_in; m_pend_v = 1'b1; end
  endtask

  // Expected {row_sel, col_out, frame_done} for the current model position.
  function automatic logic [16:0] model_outs();
    int r, w;
    logic [7:0] rs, co;
    logic fd;
    rs = '0; co = '0; fd = 1'b0;
    if (m_active) begin
      r = m_pos / ROW_LEN;
      w = m_pos % ROW_LEN;
      if (w >= BLANK_CYC) begin
        rs = 8'(1 << r);
        co = m_frame[r*8 +: 8];
      end
      fd = (m_pos == PERIOD - 1);
    end
    return {rs, co, fd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_outs());
    #1;
    check("outs", {row_sel, col_out, frame_done}, exp_q.pop_front());
    check("onehot", 64'($onehot0(row_sel)), 64'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [63:0] b);
    board_in = b; board_valid = 1'b1;
    tick();
    board_valid = 1'b0;
  endtask

  task automatic wait_row(input logic [7:0] target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (row_sel == target) found = 1'b1;
      else tick();
    end
    check("wait_row", {63'd0, found}, 64'd1);
  endtask

  // Assert reset between edges and confirm that the outputs clear before the next edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_blank", {row_sel, col_out, frame_done}, 17'd0);
    run(3);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    run(3);
    check("reset_state", {62'd0, dbg_state}, 64'd0);
    reset = 1'b1;
    enable = 1'b1;
    run(6);                                  // no board seen: stays dark

    strobe(64'h8100_0000_0000_0081);         // diagonal corners
    run(110);

    wait_row(8'h08);                         // mid row 3
    run(2);
    strobe(64'h0000_0000_0000_00FF);
    run(120);

    strobe(64'h01);                          // two strobes, last wins
    run(10);
    strobe(64'h02);
    run(110);

    wait_row(8'h20);                         // drop enable during row 5
    run(1);
    enable = 1'b0;
    run(6);
    enable = 1'b1;
    run(60);

    wait_row(8'h04);                         // reset during row 2
    async_reset();
    run(30);

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) > 3);
      if ($urandom_range(0, 59) == 0) begin
        board_in = {$urandom, $urandom}; board_valid = 1'b1;
      end else begin
        board_valid = 1'b0;
      end
      if ($urandom_range(0, 1499) == 0) begin
        board_valid = 1'b0;
        async_reset();
      end else begin
        tick();
      end
    end
    board_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
